// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, control encodings and the bubble instruction.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

endpackage

// File: rtl/regfile.sv
// 32 x XLEN register file: two async read ports with writeback bypass, one sync write port, x0 hardwired.
module regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      a1,
    input  logic [4:0]      a2,
    input  logic            we,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [1:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (a3 != 5'd0)) begin
            regs[a3] <= wd;
        end
    end

    // Same-cycle bypass lets the writeback stage resolve a RAW hazard without a stall.
    always_comb begin
        rd1 = '0;
        if (a1 != 5'd0) begin
            if (we && (a3 == a1)) begin
                rd1 = wd;
            end else begin
                rd1 = regs[a1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (a2 != 5'd0) begin
            if (we && (a3 == a2)) begin
                rd2 = wd;
            end else begin
                rd2 = regs[a2];
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, main/ALU control decode and immediate extension.
module decode_stage #(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic [XLEN-1:0] ImmExtD,
    output logic [4:0]      RdD,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [2:0]      funct3D,
    output logic            RegWriteD,
    output logic            MemWriteD,
    output logic            JumpD,
    output logic            BranchD,
    output logic            ALUSrcD,
    output logic [1:0]      ResultSrcD,
    output logic [2:0]      ALUControlD
);

    import riscv_pkg::*;

    logic [31:0] InstrD;
    logic [6:0]  opcode;
    imm_src_e    imm_src;
    alu_op_e     alu_op;
    logic        imm_valid;

    // Flush wins over stall so a redirect is never masked by a hazard hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end
    end

    assign opcode  = InstrD[6:0];
    assign RdD     = InstrD[11:7];
    assign funct3D = InstrD[14:12];
    assign Rs1D    = InstrD[19:15];
    assign Rs2D    = InstrD[24:20];

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .a1    (Rs1D),
        .a2    (Rs2D),
        .we    (RegWriteW),
        .a3    (RdW),
        .wd    (ResultW),
        .rd1   (RD1D),
        .rd2   (RD2D)
    );

    always_comb begin
        RegWriteD  = 1'b0;
        MemWriteD  = 1'b0;
        JumpD      = 1'b0;
        BranchD    = 1'b0;
        ALUSrcD    = 1'b0;
        ResultSrcD = RES_ALU;
        alu_op     = ALUOP_ADD;
        imm_src    = IMM_I;
        imm_valid  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                RegWriteD  = 1'b1;
                ALUSrcD    = 1'b1;
                ResultSrcD = RES_MEM;
                imm_valid  = 1'b1;
            end
            OP_STORE: begin
                MemWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                imm_src   = IMM_S;
                imm_valid = 1'b1;
            end
            OP_RTYPE: begin
                RegWriteD = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                BranchD   = 1'b1;
                alu_op    = ALUOP_SUB;
                imm_src   = IMM_B;
                imm_valid = 1'b1;
            end
            OP_IALU: begin
                RegWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                alu_op    = ALUOP_FUNCT;
                imm_valid = 1'b1;
            end
            OP_JAL: begin
                RegWriteD  = 1'b1;
                JumpD      = 1'b1;
                ResultSrcD = RES_PC4;
                imm_src    = IMM_J;
                imm_valid  = 1'b1;
            end
            default: ;
        endcase
    end

    // Only R-type uses instr[30] to select sub; addi with a large immediate must still add.
    always_comb begin
        ALUControlD = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: ALUControlD = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3D)
                    3'b000:  ALUControlD = ((opcode == OP_RTYPE) && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControlD = ALU_SLT;
                    3'b110:  ALUControlD = ALU_OR;
                    3'b111:  ALUControlD = ALU_AND;
                    default: ALUControlD = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        ImmExtD = '0;
        if (imm_valid) begin
            case (imm_src)
                IMM_I: ImmExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
                IMM_S: ImmExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                IMM_B: ImmExtD = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                                  InstrD[30:25], InstrD[11:8], 1'b0};
                IMM_J: ImmExtD = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                                  InstrD[20], InstrD[30:21], 1'b0};
                default: ImmExtD = '0;
            endcase
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction-decode stage of the 5-stage pipeline. It holds the IF/ID pipeline register (stall/flush), the 32x32 register file with writeback bypass, the main/ALU control decoder and the immediate extender. It feeds the ID/EX pipeline register directly; all `*D` outputs are its inputs.

Parameters:
XLEN, 32, datapath width
NOP_INSTR, 32'h0000_0013, instruction loaded on reset/flush (`addi x0,x0,0`)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
InstrF  in  32  fetched instruction
PCF  in  XLEN  PC of InstrF
PCPlus4F  in  XLEN  PCF+4
StallD  in  1  hold IF/ID register
FlushD  in  1  load bubble into IF/ID register
RegWriteW  in  1  writeback write enable
RdW  in  5  writeback destination
ResultW  in  XLEN  writeback data
RD1D, RD2D  out  XLEN  rs1/rs2 operand values
PCD, PCPlus4D  out  XLEN  registered PC, PC+4
ImmExtD  out  XLEN  sign-extended immediate
RdD, Rs1D, Rs2D  out  5  instr[11:7], [19:15], [24:20]
funct3D  out  3  instr[14:12]
RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  out  1  controls
ResultSrcD  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlD  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- IF/ID register (InstrD, PCD, PCPlus4D): async reset -> NOP_INSTR, 0, 0. At posedge: FlushD=1 -> NOP_INSTR/0/0 (flush beats stall); else StallD=1 -> hold; else capture F inputs.
- Decode outputs are combinational from the IF/ID register, so latency is one cycle from F inputs to valid D outputs.
- After reset, outputs decode NOP: RegWriteD=1, RdD=0, ALUSrcD=1, ImmExtD=0, all other controls 0, RD1D=RD2D=0.
- Register file: x1..x31 async reset to 0. At posedge, if RegWriteW and RdW!=0, write ResultW. Writes to x0 are ignored and x0 always reads 0.
- Read bypass: if RegWriteW && RdW==Rs && Rs!=0, the read returns ResultW in the same cycle. Otherwise it returns the stored value.
- Writes proceed regardless of StallD/FlushD.
- Opcode decode (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - lw 0000011: 1, I, 1, 0, 01, 0, 00, 0
  - sw 0100011: 0, S, 1, 1, xx->00, 0, 00, 0
  - R 0110011: 1, -, 0, 0, 00, 0, 10, 0
  - beq 1100011: 0, B, 0, 0, 00, 1, 01, 0
  - I-ALU 0010011: 1, I, 1, 0, 00, 0, 10, 0
  - jal 1101111: 1, J, -, 0, 10, 0, -, 1
  - Any other opcode: all controls 0 (bubble), ImmExtD=0.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct3: 000 -> sub only if R-type and funct7[5]=1, else add; 010 -> slt; 110 -> or; 111 -> and; others -> add.
- Immediates, all sign-extended from instr[31]:
  - I = [31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - J = {[31],[19:12],[20],[30:21],0}
- Reset mid-operation clears the IF/ID register and the regfile immediately (async), with no clock needed.

Decomposition:
- Package `riscv_pkg`: opcode constants, ALUControl encodings, ResultSrc encodings, ImmSrc enum (I/S/B/J), NOP_INSTR.
- Sub-module `regfile`: 2 async read ports, 1 sync write port, x0 hardwiring, write bypass, async reset. Decoder and extender stay inline.

Test Plan:
- Reset asserted with InstrF=32'h00500093 -> InstrD=NOP, PCD=0, RegWriteD=1, RdD=0, MemWriteD=0, RD1D=0.
- InstrF=32'h002081B3 (add x3,x1,x2), x1=5, x2=7 -> next cycle ALUControlD=000, RegWriteD=1, ALUSrcD=0, RdD=3, RD1D=5, RD2D=7. With 32'h402081B3 (sub) -> ALUControlD=001.
- D holds rs1=x4 while RegWriteW=1, RdW=4, ResultW=32'hDEAD_BEEF -> RD1D=32'hDEAD_BEEF in the same cycle. RdW=0 with ResultW=1 -> x0 still reads 0.
- sw with imm -4 (32'hFE20AE23) -> ImmExtD=32'hFFFF_FFFC, MemWriteD=1. beq imm -8 -> ImmExtD=32'hFFFF_FFF8. jal imm 2048 -> ImmExtD=32'h0000_0800, ResultSrcD=10, JumpD=1.
- StallD=1 for 2 cycles with changing InstrF -> InstrD/PCD unchanged. StallD=1 and FlushD=1 together -> InstrD=NOP, PCD=0.
- Opcode 7'b1111111 -> all controls 0. Assert reset mid-stream between clock edges -> outputs return to NOP decode before the next posedge.
